vv_mac: RTL
===========

VV_MAC -- requirements
Module: vv_mac

Interface
Parameters (one per line: name, default, meaning):
REQ-001 N, 4, vector length; result-memory address width is $clog2(N).
REQ-002 W, 8, signed operand width.
REQ-003 DEPTH, 4, result-memory entries; DEPTH equals N.
Ports (one per line: name  direction  width  meaning):
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  a_data/b_data are a valid operand pair this cycle.
REQ-007 a_data  input  W  signed operand A.
REQ-008 b_data  input  W  signed operand B.
REQ-009 init  input  1  the operand pair this cycle starts a new dot product.
REQ-010 mem_wr_en  input  1  commit the current dot product to the result memory.
REQ-011 wr_addr  input  $clog2(N)  result-memory entry for the commit.
REQ-012 out_rd_en  input  1  readout request.
REQ-013 out_addr  input  $clog2(N)  readout entry.
REQ-014 out_data  output  2W+$clog2(N)+1  signed readout data.
REQ-015 out_valid  output  1  out_data is valid this cycle.
REQ-016 acc_ovf  output  1  sticky flag: accumulator overflow.
REQ-017 done  output  1  all DEPTH entries written since reset.

Function
REQ-018 Accumulator width AW SHALL be 2W+$clog2(N)+1; products SHALL be sign-extended to AW.
REQ-019 Stage 1 (edge after cycle t) SHALL register prod=a_data*b_data (signed, 2W bits), together with in_valid and init, as valid_q and init_q.
REQ-020 Stage 2 SHALL update acc: if valid_q and init_q, acc<=prod; else if valid_q, acc<=acc+prod; else acc holds.
REQ-021 init SHALL be ignored when in_valid=0.
REQ-022 mem_wr_en and wr_addr SHALL be delayed 2 cycles internally (wr_en_d2, wr_addr_d2).
REQ-023 When wr_en_d2=1, mem[wr_addr_d2] SHALL take acc's pre-edge value; a commit in cycle t therefore holds all operands with in_valid through cycle t-1.
REQ-024 An operand pair with in_valid=1 in the same cycle as mem_wr_en SHALL NOT be in that commit; it SHALL accumulate normally.
REQ-025 acc arithmetic SHALL wrap in two's complement at AW bits.
REQ-026 acc_ovf SHALL set when an acc+prod addition overflows signed AW, and SHALL stay set until reset.
REQ-027 Readout SHALL have one-cycle latency: out_rd_en in cycle t gives out_valid=1 and out_data=mem[out_addr] in cycle t+1.
REQ-028 With no request, out_valid SHALL be 0 and out_data SHALL hold its last value.
REQ-029 A readout and a write to the same entry at the same edge SHALL return the old contents (read-first).
REQ-030 A 3-bit count SHALL increment on each committed write and saturate at DEPTH; done=1 when count==DEPTH.
REQ-031 Rewriting an entry SHALL overwrite it; done SHALL stay 1.

Reset
REQ-032 While rst=1 the block SHALL clear acc, prod, valid_q, init_q, wr_en_d1/d2, wr_addr_d1/d2, out_data, out_valid, acc_ovf, count and done to 0, asynchronously.
REQ-033 Result-memory contents SHALL NOT be reset; reading before writing gives undefined data.
REQ-034 When rst asserts mid-vector, partial sums and in-flight delayed commits SHALL be discarded; no memory write SHALL occur on the reset edge.

Verification
REQ-035 Basic dot product: a=(1,2,3,4) and b=(5,6,7,8) in cycles 0-3 with init in cycle 0, mem_wr_en in cycle 4 with wr_addr=0 -> later readout of entry 0 gives out_data=70 one cycle after out_rd_en.
REQ-036 Signed operands: a=(-128,-128,127,1) and b=(-128,127,127,-1) -> entry commits 16384-16256+16129-1=16256; acc_ovf stays 0.
REQ-037 Back-to-back vectors: four vectors of all-ones, each with init on its first element and a commit to wr_addr 0..3 -> all four entries read 4; done rises on the cycle after the 4th commit.
REQ-038 Same-cycle overlap: in_valid=1 with a=b=2 in the commit cycle -> the committed value excludes 4; the next commit without init includes it.
REQ-039 Mid-vector reset: assert rst after two operands, release, then run a fresh vector of (1,1,1,1)*(3,3,3,3) -> commit gives 12; done and count restart from 0.
REQ-040 Read/write collision: out_rd_en on entry 2 in the cycle its delayed write occurs -> out_data shows the old value; the next read shows the new value.

Source files
------------

// File: rtl/vv_mac.sv
// vv_mac: signed vector-vector multiply-accumulate with a small result memory and readout port.
// Latency: operand -> accumulator 2 edges; commit lands on the 2nd edge after mem_wr_en; readout 1 cycle.
// Backpressure: none; operands, commits and read requests are accepted every cycle unconditionally.
//
// Ports:
//   clk, rst               single rising-edge clock, asynchronous active-high reset
//   in_valid, a_data,
//   b_data, init           operand pair stream; init marks the first pair of a new dot product
//   mem_wr_en, wr_addr     commit the running dot product into result entry wr_addr
//   out_rd_en, out_addr    readout request; answered next cycle on out_valid/out_data
//   acc_ovf                sticky signed-overflow flag of the accumulator
//   done                   every result entry has been written at least once since reset
module vv_mac #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [W-1:0]           a_data,
  input  logic signed [W-1:0]           b_data,
  input  logic                          init,
  input  logic                          mem_wr_en,
  input  logic [$clog2(N)-1:0]          wr_addr,
  input  logic                          out_rd_en,
  input  logic [$clog2(N)-1:0]          out_addr,
  output logic signed [2*W+$clog2(N):0] out_data,
  output logic                          out_valid,
  output logic                          acc_ovf,
  output logic                          done
);

  localparam int AW = 2*W + $clog2(N) + 1;
  localparam int PW = 2*W;
  localparam int XW = AW - PW;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: product register and operand qualifiers
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_prod;
  logic                 r_valid_q;
  logic                 r_init_q;

  // Operands are widened first so the multiply is evaluated at full product width.
  assign w_a_ext = {{W{a_data[W-1]}}, a_data};
  assign w_b_ext = {{W{b_data[W-1]}}, b_data};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod    <= '0;
      r_valid_q <= 1'b0;
      r_init_q  <= 1'b0;
    end else begin
      r_prod    <= w_prod;
      r_valid_q <= in_valid;
      // init only has meaning on a valid operand pair.
      r_init_q  <= in_valid & init;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulator with sticky overflow detection
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] w_sum;
  logic                 w_add_ovf;
  logic signed [AW-1:0] r_acc;
  logic                 r_acc_ovf;

  assign w_prod_ext = {{XW{r_prod[PW-1]}}, r_prod};
  assign w_sum      = r_acc + w_prod_ext;
  // Signed overflow: both addends share a sign that the wrapped sum does not.
  assign w_add_ovf  = (r_acc[AW-1] == w_prod_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else if (r_valid_q) begin
      if (r_init_q) begin
        r_acc <= w_prod_ext;
      end else begin
        r_acc <= w_sum;
        if (w_add_ovf) begin
          r_acc_ovf <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit path
  // The request is captured on the first edge and written on the second. At
  // that second edge the accumulator holds every pair presented up to the
  // cycle before mem_wr_en, while a pair presented alongside mem_wr_en is
  // still in the product register and so falls into the next commit.
  // ---------------------------------------------------------------------------
  logic                   r_wr_en_d1;
  logic [$clog2(N)-1:0]   r_wr_addr_d1;
  logic signed [AW-1:0]   r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en_d1   <= 1'b0;
      r_wr_addr_d1 <= '0;
    end else begin
      r_wr_en_d1   <= mem_wr_en;
      r_wr_addr_d1 <= wr_addr;
    end
  end

  // Result storage is not reset; the rst term keeps a reset coinciding with a
  // clock edge from completing an in-flight commit.
  always_ff @(posedge clk) begin
    if (r_wr_en_d1 && !rst) begin
      r_mem[r_wr_addr_d1] <= r_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Write counter and done flag
  // ---------------------------------------------------------------------------
  logic [2:0] r_count;
  logic [2:0] w_count_nxt;
  logic       r_done;

  always_comb begin
    w_count_nxt = r_count;
    if (r_wr_en_d1 && (r_count != DEPTH_C)) begin
      w_count_nxt = r_count + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_done  <= (w_count_nxt == DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Readout: registered, read-first against a same-edge commit
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] r_out_data;
  logic                 r_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= out_rd_en;
      if (out_rd_en) begin
        r_out_data <= r_mem[out_addr];
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign acc_ovf   = r_acc_ovf;
  assign done      = r_done;

endmodule
